// File: rtl/countdown_timer.sv
// countdown_timer: per-player chess clock counting M:SS down once per second while flag is high.
//   clock       - system clock, rising edge
//   reset       - asynchronous active-high, reloads START_MINS:00 and clears the prescaler
//   flag        - run enable; low pauses and holds all state, including the partial second
//   SegMins     - minutes digit, active-low {g,f,e,d,c,b,a}
//   SegSecTens  - tens-of-seconds digit, same encoding
//   SegSecUnits - units-of-seconds digit, same encoding
module countdown_timer #(
    parameter int TICK_CYCLES = 50_000_000,
    parameter int START_MINS  = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       flag,
    output logic [6:0] SegMins,
    output logic [6:0] SegSecTens,
    output logic [6:0] SegSecUnits
);
    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] lastCount = PW'(TICK_CYCLES - 1);
    localparam logic [3:0] startMins = 4'(START_MINS);

    logic [PW-1:0] prescale;
    logic [3:0] mins, tens, units;
    logic expired, running, tick;

    // Once 0:00 is reached the prescaler freezes, so there is never an underflow to 9:59.
    assign expired = (mins == 4'd0) && (tens == 4'd0) && (units == 4'd0);
    assign running = flag && !expired;
    assign tick = running && (prescale == lastCount);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prescale <= '0;
            mins <= startMins;
            tens <= 4'd0;
            units <= 4'd0;
        end else if (running) begin
            prescale <= tick ? '0 : prescale + 1'b1;
            if (tick) begin
                units <= (units != 4'd0) ? units - 4'd1 : 4'd9;
                if (units == 4'd0) begin
                    tens <= (tens != 4'd0) ? tens - 4'd1 : 4'd5;
                    if (tens == 4'd0)
                        mins <= mins - 4'd1;
                end
            end
        end
    end

    function automatic logic [6:0] segOf(input logic [3:0] digit);
        case (digit)
            4'd0: segOf = 7'h40;
            4'd1: segOf = 7'h79;
            4'd2: segOf = 7'h24;
            4'd3: segOf = 7'h30;
            4'd4: segOf = 7'h19;
            4'd5: segOf = 7'h12;
            4'd6: segOf = 7'h02;
            4'd7: segOf = 7'h78;
            4'd8: segOf = 7'h00;
            4'd9: segOf = 7'h10;
            default: segOf = 7'h7F;
        endcase
    endfunction

    always_comb begin
        SegMins = segOf(mins);
        SegSecTens = segOf(tens);
        SegSecUnits = segOf(units);
    end
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed checks of two chess clocks (white/black) with TICK_CYCLES=10, START_MINS=5.
module tb_countdown_timer;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic flagW = 1'b0;
    logic flagB = 1'b0;
    logic [6:0] wMins, wTens, wUnits, bMins, bTens, bUnits;
    logic [20:0] wDisp, bDisp;
    int checks = 0;
    int failures = 0;

    countdown_timer #(.TICK_CYCLES(10), .START_MINS(5)) white (
        .clock(clock), .reset(reset), .flag(flagW),
        .SegMins(wMins), .SegSecTens(wTens), .SegSecUnits(wUnits)
    );

    countdown_timer #(.TICK_CYCLES(10), .START_MINS(5)) black (
        .clock(clock), .reset(reset), .flag(flagB),
        .SegMins(bMins), .SegSecTens(bTens), .SegSecUnits(bUnits)
    );

    assign wDisp = {wMins, wTens, wUnits};
    assign bDisp = {bMins, bTens, bUnits};

    always #5 clock = ~clock;

    function automatic logic [6:0] digitSeg(input int d);
        case (d)
            0: digitSeg = 7'h40;
            1: digitSeg = 7'h79;
            2: digitSeg = 7'h24;
            3: digitSeg = 7'h30;
            4: digitSeg = 7'h19;
            5: digitSeg = 7'h12;
            6: digitSeg = 7'h02;
            7: digitSeg = 7'h78;
            8: digitSeg = 7'h00;
            9: digitSeg = 7'h10;
            default: digitSeg = 7'h7F;
        endcase
    endfunction

    function automatic logic [20:0] showTime(input int secs);
        return {digitSeg(secs / 60), digitSeg((secs % 60) / 10), digitSeg(secs % 10)};
    endfunction

    task automatic checkValue(input string tag, input logic [20:0] observed, input logic [20:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic stepEdges(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic applyReset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    initial begin
        int wHigh, bHigh;
        stepEdges(2);
        checkValue("reset white", wDisp, 21'({7'h12, 7'h40, 7'h40}));
        checkValue("reset black", bDisp, 21'({7'h12, 7'h40, 7'h40}));
        reset = 1'b0;
        stepEdges(100);
        checkValue("paused 100", wDisp, showTime(300));

        flagW = 1'b1;
        stepEdges(9);
        checkValue("edge 9", wDisp, showTime(300));
        stepEdges(1);
        checkValue("edge 10", wDisp, 21'({7'h19, 7'h12, 7'h10}));
        stepEdges(10);
        checkValue("edge 20", wDisp, 21'({7'h19, 7'h12, 7'h00}));
        checkValue("black idle", bDisp, showTime(300));

        flagW = 1'b0;
        applyReset();
        flagW = 1'b1;
        stepEdges(5);
        flagW = 1'b0;
        stepEdges(50);
        checkValue("pause held", wDisp, showTime(300));
        flagW = 1'b1;
        stepEdges(4);
        checkValue("resume 9th", wDisp, showTime(300));
        stepEdges(1);
        checkValue("resume 10th", wDisp, showTime(299));

        applyReset();
        stepEdges(2999);
        checkValue("before expiry", wDisp, showTime(1));
        stepEdges(1);
        checkValue("expired", wDisp, showTime(0));
        stepEdges(100);
        checkValue("stay expired", wDisp, showTime(0));
        flagW = 1'b0;
        stepEdges(5);
        checkValue("expired paused", wDisp, showTime(0));

        applyReset();
        flagW = 1'b1;
        stepEdges(930);
        checkValue("at 3:27", wDisp, showTime(207));
        #3;
        reset = 1'b1;
        #1;
        checkValue("async reset", wDisp, showTime(300));
        #2;
        reset = 1'b0;
        stepEdges(9);
        checkValue("post reset 9", wDisp, showTime(300));
        stepEdges(1);
        checkValue("post reset 10", wDisp, showTime(299));

        flagW = 1'b0;
        applyReset();
        wHigh = 0;
        bHigh = 0;
        for (int k = 0; k < 8; k++) begin
            flagW = (k % 2 == 0);
            flagB = ~flagW;
            stepEdges(25);
            if (flagW) wHigh += 25;
            else bHigh += 25;
            checkValue($sformatf("alt white %0d", k), wDisp, showTime(300 - wHigh / 10));
            checkValue($sformatf("alt black %0d", k), bDisp, showTime(300 - bHigh / 10));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule
